// File: rtl/proc_io_if.sv
// Processor I/O bus: input-channel read port, output-channel write port
// with stall, and the trace FIFO val/rdy drain port.
interface proc_io_if #(
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_IN*DATA_W-1:0]  in_data;
  logic [3:0]                rd_idx;
  logic [DATA_W-1:0]         rd_data;
  logic                      wr_en;
  logic [3:0]                wr_idx;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_stall;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic                      trace_val;
  logic                      trace_rdy;
  logic [3:0]                trace_idx;
  logic [DATA_W-1:0]         trace_data;

  // Processor / consumer side
  modport master (
    output in_data, rd_idx, wr_en, wr_idx, wr_data, trace_rdy,
    input  rd_data, wr_stall, out_data, trace_val, trace_idx, trace_data
  );

  // I/O unit side
  modport slave (
    input  in_data, rd_idx, wr_en, wr_idx, wr_data, trace_rdy,
    output rd_data, wr_stall, out_data, trace_val, trace_idx, trace_data
  );
endinterface

// File: rtl/proc_io_unit.sv
// Processor I/O unit: NUM_IN input channels read through a channel mux,
// NUM_OUT registered output channels, and a TRACE_DEPTH-entry trace FIFO
// recording every accepted output write. A full FIFO stalls the writer
// unless the head is being drained in the same cycle.
// Optional macro PROC_IO_UNIT_IN_SYNC_EN: two-flop synchronizer on each
// input channel ahead of the read mux (2-cycle read latency).
module proc_io_unit #(
  parameter int unsigned NUM_IN      = 3,
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  proc_io_if.slave   io
);

  localparam int unsigned PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(TRACE_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TRACE_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TRACE_DEPTH);

  logic [NUM_IN*DATA_W-1:0] in_view;

`ifdef PROC_IO_UNIT_IN_SYNC_EN
  logic [NUM_IN*DATA_W-1:0] sync_meta_q;
  logic [NUM_IN*DATA_W-1:0] sync_out_q;

  // Two-flop synchronizer on all input channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= '0;
      sync_out_q  <= '0;
    end else begin
      sync_meta_q <= io.in_data;
      sync_out_q  <= sync_meta_q;
    end
  end

  assign in_view = sync_out_q;
`else
  assign in_view = io.in_data;
`endif

  logic [DATA_W-1:0] rd_data_c;

  // Input channel mux; out-of-range index reads zero
  always_comb begin
    rd_data_c = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (io.rd_idx == 4'(k)) rd_data_c = in_view[k*DATA_W +: DATA_W];
    end
  end

  assign io.rd_data = rd_data_c;

  logic [PTR_W-1:0]          head_q;
  logic [PTR_W-1:0]          tail_q;
  logic [CNT_W-1:0]          count_q;
  logic [3:0]                idx_mem  [TRACE_DEPTH];
  logic [DATA_W-1:0]         data_mem [TRACE_DEPTH];
  logic [NUM_OUT*DATA_W-1:0] out_q;

  logic trace_val_c;
  logic deq_c;
  logic full_c;
  logic wr_hit_c;
  logic stall_c;
  logic enq_c;

  // Acceptance: a full FIFO only takes a write when its head leaves this cycle
  assign trace_val_c = (count_q != '0);
  assign deq_c       = trace_val_c & io.trace_rdy;
  assign full_c      = (count_q == FULL_CNT);
  assign wr_hit_c    = ({28'd0, io.wr_idx} < 32'(NUM_OUT));
  assign stall_c     = io.wr_en & wr_hit_c & full_c & ~deq_c;
  assign enq_c       = io.wr_en & wr_hit_c & ~stall_c;

  assign io.wr_stall   = stall_c;
  assign io.out_data   = out_q;
  assign io.trace_val  = trace_val_c;
  assign io.trace_idx  = idx_mem[head_q];
  assign io.trace_data = data_mem[head_q];

  // Output channel registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (enq_c && (io.wr_idx == 4'(k))) out_q[k*DATA_W +: DATA_W] <= io.wr_data;
      end
    end
  end

  // Trace FIFO storage and circular pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < TRACE_DEPTH; i++) begin
        idx_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (enq_c) begin
        idx_mem[tail_q]  <= io.wr_idx;
        data_mem[tail_q] <= io.wr_data;
        tail_q           <= (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
      end
      if (deq_c) begin
        head_q <= (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
      end
    end
  end

  // Occupancy: unchanged when enqueue and dequeue coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({enq_c, deq_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
